// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive-side TDM demultiplexer, four slots per frame.
// Distributes each accepted word to one of four registered channels, tracks
// frame lock with a miss flywheel, and flags frame_sync seen at a non-zero slot.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   din, din_valid  TDM word and its qualifier
//   frame_sync      marks the current valid word as slot 0
//   ch0..ch3        last word captured for slots 0..3 (held)
//   ch_valid        one-cycle per-channel update strobes
//   frame_done      one-cycle pulse with ch_valid[3]
//   slot            slot index expected for the next valid word
//   locked          high while frame lock is held
//   sync_err        one-cycle pulse on frame_sync at slot 1..3
module tdm_demux_4ch #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_MISS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    localparam int unsigned NCH    = 4;
    localparam int unsigned MISS_W = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  slot_q, slot_d;
    logic [MISS_W-1:0]           miss_q, miss_d, miss_inc;
    logic [NCH-1:0][WIDTH-1:0]   ch_q, ch_d;
    logic [NCH-1:0]              cv_q, cv_d;
    logic                        fd_q, fd_d;
    logic                        se_q, se_d;

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            miss_q  <= '0;
            ch_q    <= '0;
            cv_q    <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            miss_q  <= miss_d;
            ch_q    <= ch_d;
            cv_q    <= cv_d;
            fd_q    <= fd_d;
            se_q    <= se_d;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        miss_d   = miss_q;
        ch_d     = ch_q;
        cv_d     = '0;
        fd_d     = 1'b0;
        se_d     = 1'b0;
        miss_inc = miss_q + MISS_W'(1);

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Unsynced words are dropped until the first frame_sync.
                    if (frame_sync) begin
                        ch_d[0] = din;
                        cv_d    = 4'b0001;
                        slot_d  = 2'd1;
                        miss_d  = '0;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot_q != 2'd0)) begin
                        // Misaligned sync: realign on this word as slot 0.
                        se_d    = 1'b1;
                        ch_d[0] = din;
                        cv_d    = 4'b0001;
                        slot_d  = 2'd1;
                        miss_d  = '0;
                    end else begin
                        ch_d[slot_q] = din;
                        cv_d[slot_q] = 1'b1;
                        slot_d       = slot_q + 2'd1;
                        fd_d         = (slot_q == 2'd3);
                        if (slot_q == 2'd0) begin
                            if (frame_sync) begin
                                miss_d = '0;
                            end else if (miss_inc == MISS_W'(MAX_MISS)) begin
                                // Too many flywheel frames: drop lock.
                                state_d = HUNT;
                                slot_d  = 2'd0;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign ch_valid   = cv_q;
    assign frame_done = fd_q;
    assign sync_err   = se_q;
    assign slot       = slot_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch (WIDTH=4, MAX_MISS=2). Stimulus pushes
// hand-computed expected output snapshots; a negedge monitor pops one
// whenever the DUT strobes ch_valid/frame_done/sync_err.
module tb_tdm_demux_4ch;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int total  = 0;
    int passed = 0;

    // Snapshot: {ch_valid, ch3, ch2, ch1, ch0, frame_done, sync_err, slot, locked}
    logic [24:0] expq[$];

    tdm_demux_4ch #(.WIDTH(W), .MAX_MISS(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .ch_valid(ch_valid), .frame_done(frame_done), .slot(slot),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] mk(input logic [3:0] cv,
                                       input logic [3:0] c0, input logic [3:0] c1,
                                       input logic [3:0] c2, input logic [3:0] c3,
                                       input logic fd, input logic se,
                                       input logic [1:0] sl, input logic lk);
        return {cv, c3, c2, c1, c0, fd, se, sl, lk};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Drive one accepted word; optionally queue the expected snapshot.
    task automatic send(input logic [3:0] d, input logic s, input bit has,
                        input logic [24:0] e);
        din        = d;
        frame_sync = s;
        din_valid  = 1'b1;
        if (has) expq.push_back(e);
        @(posedge clk); #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ch"}, {16'd0, ch3, ch2, ch1, ch0}, 32'd0);
        chk({tag, "_pulses"}, {26'd0, ch_valid, frame_done, sync_err}, 32'd0);
        chk({tag, "_slot"}, {30'd0, slot}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ch_valid != 4'd0 || frame_done || sync_err) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got %h expected none",
                         {ch_valid, ch3, ch2, ch1, ch0, frame_done, sync_err, slot, locked});
            end else begin
                chk("scoreboard", {7'd0, ch_valid, ch3, ch2, ch1, ch0,
                                   frame_done, sync_err, slot, locked},
                    {7'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        idle(3);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        idle(5);
        chk_all_zero("idle_after_reset");

        // HUNT discard, lock on 5, gap, then continue the frame
        send(4'h1, 1'b0, 0, '0);
        send(4'h2, 1'b0, 0, '0);
        chk("hunt_slot", {30'd0, slot}, 32'd0);
        chk("hunt_locked", {31'd0, locked}, 32'd0);
        send(4'h5, 1'b1, 1, mk(4'b0001, 4'h5, 4'h0, 4'h0, 4'h0, 0, 0, 2'd1, 1));
        idle(1);
        chk("gap_ch_valid", {28'd0, ch_valid}, 32'd0);
        idle(1);
        chk("gap_ch_valid2", {28'd0, ch_valid}, 32'd0);
        send(4'h6, 1'b0, 1, mk(4'b0010, 4'h5, 4'h6, 4'h0, 4'h0, 0, 0, 2'd2, 1));
        send(4'h7, 1'b0, 1, mk(4'b0100, 4'h5, 4'h6, 4'h7, 4'h0, 0, 0, 2'd3, 1));
        send(4'h8, 1'b0, 1, mk(4'b1000, 4'h5, 4'h6, 4'h7, 4'h8, 1, 0, 2'd0, 1));

        // Full synced frame A,B,C,D
        send(4'hA, 1'b1, 1, mk(4'b0001, 4'hA, 4'h6, 4'h7, 4'h8, 0, 0, 2'd1, 1));
        send(4'hB, 1'b0, 1, mk(4'b0010, 4'hA, 4'hB, 4'h7, 4'h8, 0, 0, 2'd2, 1));
        send(4'hC, 1'b0, 1, mk(4'b0100, 4'hA, 4'hB, 4'hC, 4'h8, 0, 0, 2'd3, 1));
        send(4'hD, 1'b0, 1, mk(4'b1000, 4'hA, 4'hB, 4'hC, 4'hD, 1, 0, 2'd0, 1));

        // Misaligned sync at slot 2
        send(4'h1, 1'b1, 1, mk(4'b0001, 4'h1, 4'hB, 4'hC, 4'hD, 0, 0, 2'd1, 1));
        send(4'h2, 1'b0, 1, mk(4'b0010, 4'h1, 4'h2, 4'hC, 4'hD, 0, 0, 2'd2, 1));
        send(4'h9, 1'b1, 1, mk(4'b0001, 4'h9, 4'h2, 4'hC, 4'hD, 0, 1, 2'd1, 1));
        idle(1);
        chk("sync_err_one_cycle", {31'd0, sync_err}, 32'd0);

        // Lock loss: two frames starting without frame_sync
        send(4'h3, 1'b0, 1, mk(4'b0010, 4'h9, 4'h3, 4'hC, 4'hD, 0, 0, 2'd2, 1));
        send(4'h4, 1'b0, 1, mk(4'b0100, 4'h9, 4'h3, 4'h4, 4'hD, 0, 0, 2'd3, 1));
        send(4'h5, 1'b0, 1, mk(4'b1000, 4'h9, 4'h3, 4'h4, 4'h5, 1, 0, 2'd0, 1));
        send(4'h6, 1'b0, 1, mk(4'b0001, 4'h6, 4'h3, 4'h4, 4'h5, 0, 0, 2'd1, 1));
        send(4'h7, 1'b0, 1, mk(4'b0010, 4'h6, 4'h7, 4'h4, 4'h5, 0, 0, 2'd2, 1));
        send(4'h8, 1'b0, 1, mk(4'b0100, 4'h6, 4'h7, 4'h8, 4'h5, 0, 0, 2'd3, 1));
        send(4'h9, 1'b0, 1, mk(4'b1000, 4'h6, 4'h7, 4'h8, 4'h9, 1, 0, 2'd0, 1));
        send(4'hE, 1'b0, 1, mk(4'b0001, 4'hE, 4'h7, 4'h8, 4'h9, 0, 0, 2'd0, 0));
        send(4'h1, 1'b0, 0, '0);
        send(4'h2, 1'b0, 0, '0);
        chk("lost_locked", {31'd0, locked}, 32'd0);
        chk("lost_slot", {30'd0, slot}, 32'd0);
        chk("lost_ch0_held", {28'd0, ch0}, 32'hE);
        chk("lost_ch1_held", {28'd0, ch1}, 32'h7);

        // Reset mid-frame (slot 2) with a competing synced word
        send(4'hF, 1'b1, 1, mk(4'b0001, 4'hF, 4'h7, 4'h8, 4'h9, 0, 0, 2'd1, 1));
        send(4'h1, 1'b0, 1, mk(4'b0010, 4'hF, 4'h1, 4'h8, 4'h9, 0, 0, 2'd2, 1));
        rst_n = 1'b0; din = 4'h3; frame_sync = 1'b1; din_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; din_valid = 1'b0; frame_sync = 1'b0;
        chk_all_zero("mid_reset");
        send(4'h4, 1'b0, 0, '0);
        chk_all_zero("after_reset_discard");

        idle(3);
        chk("queue_drained", expq.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
